// File: rtl/fifo_reader.sv
// ---------------------------------------------------------------------------
// fifo_reader
//   Pulls words out of a synchronous FIFO (one-cycle read latency) and
//   presents them on a valid/ready stream. A 2-entry skid buffer absorbs the
//   read latency, so the block sustains one word per cycle while never
//   issuing a read that would not fit.
//
// Ports
//   clk           : single clock, rising edge
//   rst           : asynchronous active-high reset
//   en            : read enable; low stops new FIFO reads (in-flight data
//                   and buffered words still drain)
//   fifo_empty    : FIFO empty flag
//   fifo_data_out : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    : FIFO read strobe (combinational)
//   m_valid       : downstream word valid
//   m_data        : downstream word (buffer head)
//   m_ready       : downstream accept
//   word_count    : words accepted downstream, wraps modulo 2^CNT_WIDTH
//   busy          : a read is in flight or the buffer holds data
// ---------------------------------------------------------------------------
module fifo_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  busy
);

  logic [DATA_WIDTH-1:0] data_buf [2];
  logic                  head;
  logic                  tail;
  logic [1:0]            occ;
  logic                  inflight;
  logic                  pop;
  logic [2:0]            occ_next;

  assign pop     = m_valid && m_ready;
  assign m_valid = (occ != 2'd0);
  assign m_data  = data_buf[head];
  assign busy    = inflight || (occ != 2'd0);

  // Occupancy once this cycle's in-flight word lands and any pop leaves.
  // A new read is only allowed if that leaves room for its word next cycle.
  assign occ_next = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  // rst gates the strobe directly so no read is issued while reset is held,
  // even though en and fifo_empty may say otherwise.
  assign fifo_rd_en = !rst && en && !fifo_empty && (occ_next < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ        <= 2'd0;
      inflight   <= 1'b0;
      head       <= 1'b0;
      tail       <= 1'b0;
      word_count <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge values of the others, independent of statement order.
      inflight <= fifo_rd_en;
      occ      <= occ_next[1:0];
      if (inflight) tail <= ~tail;
      if (pop) begin
        head       <= ~head;
        word_count <= word_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  // NOTE: the data storage is deliberately left out of reset; occ alone
  // decides which entries are meaningful, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (inflight) data_buf[tail] <= fifo_data_out;
  end

endmodule

// File: tb/tb_fifo_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_reader
//   Self-checking bench for fifo_reader (CNT_WIDTH=4 to reach the counter
//   wrap quickly). The FIFO is modelled as a queue; the reference model keeps
//   the expected delivery order as a second queue and tracks words read vs.
//   words delivered as plain counters.
// ---------------------------------------------------------------------------
module tb_fifo_reader;

  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data_out = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic [CW-1:0] word_count;
  logic          busy;

  fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .fifo_empty   (fifo_empty),
    .fifo_data_out(fifo_data_out),
    .fifo_rd_en   (fifo_rd_en),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .word_count   (word_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            reads_done;
  int            pops_done;
  int            cyc;
  int            last_pop_cyc;
  int            streak;
  logic          prev_hold;
  logic [DW-1:0] prev_data;
  logic          rd_seen;
  logic [7:0]    wc_snap [32];

  // Snapshot of DUT outputs at the most recent negedge
  logic          snap_rd, snap_valid, snap_busy;
  logic [DW-1:0] snap_data;
  logic [CW-1:0] snap_count;

  typedef struct {
    logic          en;
    logic          rdy;
    logic          rd_en;
    logic          valid;
    logic [DW-1:0] data;
    logic          busy;
    logic [CW-1:0] count;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // Observes one cycle at the negedge, where inputs and outputs are stable.
  task automatic monitor();
    int outstanding;
    logic pop;
    snap_rd    = fifo_rd_en;
    snap_valid = m_valid;
    snap_data  = m_data;
    snap_busy  = busy;
    snap_count = word_count;
    rd_seen    = 1'b0;
    if (rst) return;
    outstanding = reads_done - pops_done;
    pop = m_valid && m_ready;
    check("busy", busy, outstanding != 0);
    check("word_count", word_count, pops_done % 16);
    check("buffer_bound", outstanding <= 2, 1);
    check("no_underflow", fifo_rd_en && fifo_empty, 0);
    if (pops_done < 32) wc_snap[pops_done] = 8'(word_count);
    if (prev_hold) begin
      check("hold_valid", m_valid, 1);
      check("hold_data", m_data, prev_data);
    end
    if (pop) begin
      check("word_available", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("m_data_order", m_data, exp_q.pop_front());
      pops_done++;
      streak = (last_pop_cyc == cyc - 1) ? streak + 1 : 1;
      last_pop_cyc = cyc;
    end
    if (fifo_rd_en) reads_done++;
    rd_seen   = fifo_rd_en;
    prev_hold = m_valid && !m_ready;
    prev_data = m_data;
    cyc++;
  endtask

  // One clock: observe, then the FIFO model responds just after the edge.
  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (rd_seen && fifo_q.size() != 0) fifo_data_out = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_word_count", word_count, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    fifo_q.delete();
    exp_q.delete();
    fifo_empty   = 1'b1;
    reads_done   = 0;
    pops_done    = 0;
    prev_hold    = 1'b0;
    last_pop_cyc = -10;
    streak       = 0;
    for (int i = 0; i < 32; i++) wc_snap[i] = 8'hFF;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  task automatic drain();
    int budget;
    en = 1'b1;
    m_ready = 1'b1;
    budget = 200;
    while ((exp_q.size() != 0 || reads_done != pops_done) && budget > 0) begin
      cycle();
      budget--;
    end
    check("drain_timeout", exp_q.size() + (reads_done - pops_done), 0);
  endtask

  initial begin
    int r0;
    cyc = 0;

    tbl[0] = '{en:1, rdy:1, rd_en:1, valid:0, data:16'h0000, busy:0, count:4'd0};
    tbl[1] = '{en:1, rdy:1, rd_en:0, valid:0, data:16'h0000, busy:1, count:4'd0};
    tbl[2] = '{en:1, rdy:0, rd_en:0, valid:1, data:16'h00A5, busy:1, count:4'd0};
    tbl[3] = '{en:1, rdy:1, rd_en:0, valid:1, data:16'h00A5, busy:1, count:4'd0};
    tbl[4] = '{en:1, rdy:1, rd_en:0, valid:0, data:16'h0000, busy:0, count:4'd1};

    // Reset holds outputs low even with en=1 and a non-empty FIFO.
    en = 1'b1;
    push(16'h1234);
    apply_reset();

    // Single word, with one cycle of backpressure on the delivery.
    push(16'h00A5);
    for (int i = 0; i < 5; i++) begin
      en = tbl[i].en;
      m_ready = tbl[i].rdy;
      cycle();
      check($sformatf("tbl%0d_rd_en", i), snap_rd, tbl[i].rd_en);
      check($sformatf("tbl%0d_valid", i), snap_valid, tbl[i].valid);
      if (tbl[i].valid) check($sformatf("tbl%0d_data", i), snap_data, tbl[i].data);
      check($sformatf("tbl%0d_busy", i), snap_busy, tbl[i].busy);
      check($sformatf("tbl%0d_count", i), snap_count, tbl[i].count);
    end

    // Streaming: 8 words delivered on consecutive cycles.
    for (int i = 1; i <= 8; i++) push(DW'(i));
    r0 = pops_done;
    drain();
    check("stream_pops", pops_done - r0, 8);
    check("stream_streak", streak, 8);

    // Backpressure: only two reads fit, head word held.
    m_ready = 1'b0;
    en = 1'b1;
    r0 = reads_done;
    for (int i = 0; i < 4; i++) push(DW'($urandom));
    begin
      logic [DW-1:0] first_w;
      first_w = exp_q[0];
      repeat (10) cycle();
      check("bp_reads", reads_done - r0, 2);
      check("bp_valid", snap_valid, 1);
      check("bp_data", snap_data, first_w);
    end
    drain();

    // Disable right after one read: that word still arrives, nothing more.
    m_ready = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 3; i++) push(DW'($urandom));
    r0 = reads_done;
    cycle();
    en = 1'b0;
    repeat (6) cycle();
    check("dis_reads", reads_done - r0, 1);
    check("dis_busy", snap_busy, 0);
    check("dis_fifo_left", fifo_q.size(), 2);
    drain();

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      m_ready = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) push(DW'($urandom));
      cycle();
    end
    drain();

    // Reset mid-stream with a full buffer.
    m_ready = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 5; i++) push(DW'($urandom));
    repeat (4) cycle();
    check("mid_occ_full", reads_done - pops_done, 2);
    check("mid_count_nonzero", snap_count != 0, 1);
    apply_reset();
    m_ready = 1'b1;
    repeat (5) cycle();
    check("post_reset_idle", snap_valid, 0);
    check("post_reset_reads", reads_done, 0);

    // Counter wrap with a 4-bit counter.
    apply_reset();
    for (int i = 0; i < 17; i++) push(DW'(16'h0100 + i));
    drain();
    cycle();
    check("wrap_15", wc_snap[15], 8'h0F);
    check("wrap_16", wc_snap[16], 8'h00);
    check("wrap_17", wc_snap[17], 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
